// File: rtl/halt_monitor_pkg.sv
// halt_monitor_pkg: shared state and error-code encodings for the halt monitor
package halt_monitor_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        SETTLE = 2'd1,
        DONE   = 2'd2,
        ERROR  = 2'd3
    } stateT;

    typedef enum logic [1:0] {
        ERR_NONE      = 2'd0,
        ERR_TIMEOUT   = 2'd1,
        ERR_HALT_DROP = 2'd2,
        ERR_WORD_CHG  = 2'd3
    } errCodeT;

endpackage

// File: rtl/sat_counter.sv
// sat_counter: up-counter with enable, synchronous clear and saturation at all-ones
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         en,
    input  logic         clr,
    output logic [W-1:0] cnt
);

    // Clear wins over increment; the count sticks once it reaches all-ones.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) cnt <= '0;
        else if (clr) cnt <= '0;
        else if (en && cnt != '1) cnt <= cnt + 1'b1;
    end

endmodule

// File: rtl/halt_monitor.sv
// halt_monitor: watches a DUT for its first halt, then checks the halt and result word stay put
module halt_monitor
    import halt_monitor_pkg::*;
#(
    parameter int DATA_W        = 16,
    parameter int CNT_W         = 32,
    parameter int TIMEOUT       = 3000,
    parameter int SETTLE_CYCLES = 5,
    parameter int CHECK_EN      = 0
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              en,
    input  logic              halt,
    input  logic [DATA_W-1:0] firstWord,
    output logic              done,
    output logic              pass,
    output logic [1:0]        errCode,
    output logic [DATA_W-1:0] wordAtHalt,
    output logic [CNT_W-1:0]  clkAtHalt,
    output logic [CNT_W-1:0]  clkCnt
);

    localparam bit          CHK         = CHECK_EN != 0;
    localparam logic [7:0]  SETTLE_LAST = 8'(SETTLE_CYCLES - 1);

    stateT             state, stateNext;
    errCodeT           err, errNext;
    logic              active, capture;
    logic [CNT_W-1:0]  cntNext;
    logic [7:0]        settleCnt;

    assign active  = en && (state == RUN || state == SETTLE);
    assign capture = active && state == RUN && halt;
    assign cntNext = (clkCnt == '1) ? clkCnt : clkCnt + 1'b1;

    // The settle counter tracks active edges since capture, i.e. clkCnt - clkAtHalt.
    sat_counter #(.W(CNT_W)) clkCounter (
        .clk  (clk),
        .rstn (rstn),
        .en   (active),
        .clr  (1'b0),
        .cnt  (clkCnt)
    );

    sat_counter #(.W(8)) settleCounter (
        .clk  (clk),
        .rstn (rstn),
        .en   (active && state == SETTLE),
        .clr  (capture),
        .cnt  (settleCnt)
    );

    // Next state and error code; errors outrank completion on the same edge.
    always_comb begin
        stateNext = state;
        errNext   = err;
        if (active && state == RUN) begin
            if (halt) begin
                stateNext = SETTLE;
            end else if (CHK && cntNext > CNT_W'(TIMEOUT)) begin
                stateNext = ERROR;
                errNext   = ERR_TIMEOUT;
            end
        end else if (active && state == SETTLE) begin
            if (CHK && !halt) begin
                stateNext = ERROR;
                errNext   = ERR_HALT_DROP;
            end else if (CHK && firstWord != wordAtHalt) begin
                stateNext = ERROR;
                errNext   = ERR_WORD_CHG;
            end else if (settleCnt == SETTLE_LAST) begin
                stateNext = DONE;
            end
        end
    end

    // State, error code and the one-shot capture of the first halt.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= RUN;
            err        <= ERR_NONE;
            wordAtHalt <= '0;
            clkAtHalt  <= '0;
        end else begin
            state <= stateNext;
            err   <= errNext;
            if (capture) begin
                wordAtHalt <= firstWord;
                clkAtHalt  <= cntNext;
            end
        end
    end

    assign done    = state == DONE || state == ERROR;
    assign pass    = state == DONE;
    assign errCode = err;

endmodule

// File: tb/tb_halt_monitor.sv
// tb_halt_monitor: directed checks of halt_monitor with checking on and off against a reference model
module tb_halt_monitor;

    logic        clk = 0;
    logic        rstn = 0;
    logic        en = 0;
    logic        halt = 0;
    logic [15:0] firstWord = '0;

    logic        done [2];
    logic        pass [2];
    logic [1:0]  errCode [2];
    logic [15:0] wordAtHalt [2];
    logic [31:0] clkAtHalt [2];
    logic [31:0] clkCnt [2];

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    halt_monitor #(.DATA_W(16), .CNT_W(32), .TIMEOUT(3000), .SETTLE_CYCLES(5), .CHECK_EN(0)) dut0 (
        .clk(clk), .rstn(rstn), .en(en), .halt(halt), .firstWord(firstWord),
        .done(done[0]), .pass(pass[0]), .errCode(errCode[0]),
        .wordAtHalt(wordAtHalt[0]), .clkAtHalt(clkAtHalt[0]), .clkCnt(clkCnt[0])
    );

    halt_monitor #(.DATA_W(16), .CNT_W(32), .TIMEOUT(3000), .SETTLE_CYCLES(5), .CHECK_EN(1)) dut1 (
        .clk(clk), .rstn(rstn), .en(en), .halt(halt), .firstWord(firstWord),
        .done(done[1]), .pass(pass[1]), .errCode(errCode[1]),
        .wordAtHalt(wordAtHalt[1]), .clkAtHalt(clkAtHalt[1]), .clkCnt(clkCnt[1])
    );

    // Reference model: index 0 has checking off, index 1 has checking on.
    bit          mHalted [2];
    bit          mTerm [2];
    bit [1:0]    mErr [2];
    bit [31:0]   mCnt [2];
    bit [31:0]   mHaltAt [2];
    bit [15:0]   mWord [2];

    task automatic modelReset();
        for (int k = 0; k < 2; k++) begin
            mHalted[k] = 0;
            mTerm[k]   = 0;
            mErr[k]    = 0;
            mCnt[k]    = 0;
            mHaltAt[k] = 0;
            mWord[k]   = 0;
        end
    endtask

    always @(negedge rstn) modelReset();

    always @(posedge clk) begin
        if (rstn && en) begin
            for (int k = 0; k < 2; k++) begin
                if (!mTerm[k]) begin
                    if (mCnt[k] != 32'hFFFF_FFFF) mCnt[k] = mCnt[k] + 1;
                    if (!mHalted[k]) begin
                        if (halt) begin
                            mHalted[k] = 1;
                            mHaltAt[k] = mCnt[k];
                            mWord[k]   = firstWord;
                        end else if (k == 1 && mCnt[k] > 3000) begin
                            mTerm[k] = 1;
                            mErr[k]  = 1;
                        end
                    end else if (k == 1 && !halt) begin
                        mTerm[k] = 1;
                        mErr[k]  = 2;
                    end else if (k == 1 && firstWord != mWord[k]) begin
                        mTerm[k] = 1;
                        mErr[k]  = 3;
                    end else if (mCnt[k] - mHaltAt[k] == 5) begin
                        mTerm[k] = 1;
                    end
                end
            end
        end
    end

    // Every cycle, both monitors must agree with the model.
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            logic [83:0] act, exp;
            act = {done[k], pass[k], errCode[k], clkCnt[k], clkAtHalt[k], wordAtHalt[k]};
            exp = {mTerm[k], mTerm[k] && mErr[k] == 0, mErr[k], mCnt[k], mHaltAt[k], mWord[k]};
            checks++;
            if (act !== exp) begin
                failures++;
                $display("FAIL model_cmp chk%0d t=%0t got=%h want=%h", k, $time, act, exp);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h want=%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic h, input logic [15:0] w, input logic e);
        halt = h;
        firstWord = w;
        en = e;
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n, input logic h, input logic [15:0] w);
        repeat (n) drive(h, w, 1'b1);
    endtask

    task automatic doReset();
        rstn = 0;
        en = 0;
        halt = 0;
        firstWord = '0;
        repeat (2) @(posedge clk);
        #1;
        rstn = 1;
    endtask

    initial begin
        doReset();
        chk("reset_done", {31'd0, done[1]}, 0);
        chk("reset_clkCnt", clkCnt[1], 0);

        // Halt on edge 100 with a stable word completes after edge 105.
        run(99, 0, 16'h1234);
        run(1, 1, 16'h1234);
        chk("a_clkAtHalt", clkAtHalt[1], 100);
        chk("a_wordAtHalt", {16'd0, wordAtHalt[1]}, 32'h1234);
        run(4, 1, 16'h1234);
        chk("a_not_done_104", {31'd0, done[1]}, 0);
        run(1, 1, 16'h1234);
        chk("a_done", {31'd0, done[1]}, 1);
        chk("a_pass", {31'd0, pass[1]}, 1);
        run(3, 0, 16'hBEEF);
        run(2, 1, 16'h4321);
        chk("a_clkCnt_frozen", clkCnt[1], 105);
        chk("a_capture_kept", {16'd0, wordAtHalt[1]}, 32'h1234);
        chk("a_errCode", {30'd0, errCode[1]}, 0);

        // No halt: timeout fires on edge 3001.
        doReset();
        run(3000, 0, 16'h0);
        chk("b_no_err_3000", {31'd0, done[1]}, 0);
        run(1, 0, 16'h0);
        chk("b_timeout_code", {30'd0, errCode[1]}, 1);
        chk("b_timeout_pass", {31'd0, pass[1]}, 0);
        chk("b_nocheck_running", {31'd0, done[0]}, 0);

        // Halt on edge 3001 wins over the timeout.
        doReset();
        run(3000, 0, 16'h0);
        run(1, 1, 16'h00AB);
        chk("b2_no_err", {31'd0, done[1]}, 0);
        chk("b2_clkAtHalt", clkAtHalt[1], 3001);
        run(5, 1, 16'h00AB);
        chk("b2_pass", {31'd0, pass[1]}, 1);

        // Halt drops on edge 52 while the word also changes: halt drop reported.
        doReset();
        run(49, 0, 16'h0007);
        run(2, 1, 16'h00AA);
        run(1, 0, 16'h00BB);
        chk("c_errCode", {30'd0, errCode[1]}, 2);
        chk("c_done", {31'd0, done[1]}, 1);
        run(4, 0, 16'h00BB);
        chk("c_nocheck_pass", {31'd0, pass[0]}, 1);
        chk("c_nocheck_clkCnt", clkCnt[0], 55);

        // Word changes on edge 55: word-change error instead of completion.
        doReset();
        run(49, 0, 16'h0007);
        run(5, 1, 16'h0007);
        run(1, 1, 16'h0008);
        chk("d_errCode", {30'd0, errCode[1]}, 3);
        chk("d_not_pass", {31'd0, pass[1]}, 0);
        chk("d_nocheck_pass", {31'd0, pass[0]}, 1);

        // Enable low for 10 cycles in SETTLE delays completion by exactly 10 cycles.
        doReset();
        run(9, 0, 16'h0055);
        run(3, 1, 16'h0055);
        repeat (10) drive(1, 16'h0055, 0);
        chk("e_clkCnt_frozen", clkCnt[1], 12);
        run(2, 1, 16'h0055);
        chk("e_not_done", {31'd0, done[1]}, 0);
        run(1, 1, 16'h0055);
        chk("e_done", {31'd0, pass[1]}, 1);
        chk("e_clkCnt", clkCnt[1], 15);

        // Reset pulse mid-SETTLE clears everything at once; a fresh halt is captured.
        doReset();
        run(9, 0, 16'h0099);
        run(3, 1, 16'h0099);
        rstn = 0;
        #1;
        chk("f_rst_clkCnt", clkCnt[1], 0);
        chk("f_rst_clkAtHalt", clkAtHalt[1], 0);
        chk("f_rst_word", {16'd0, wordAtHalt[1]}, 0);
        repeat (2) @(posedge clk);
        #1;
        halt = 0;
        rstn = 1;
        run(19, 0, 16'h0042);
        run(1, 1, 16'h0042);
        chk("f_clkAtHalt", clkAtHalt[1], 20);
        run(5, 1, 16'h0042);
        chk("f_pass", {31'd0, pass[1]}, 1);
        chk("f_clkCnt", clkCnt[1], 25);

        // Checking off: halt dropping on edge 12 is ignored, completion after edge 15.
        doReset();
        run(9, 0, 16'h0003);
        run(2, 1, 16'h0003);
        run(3, 0, 16'h0003);
        chk("g_not_done", {31'd0, done[0]}, 0);
        run(1, 0, 16'h0003);
        chk("g_pass", {31'd0, pass[0]}, 1);
        chk("g_errCode", {30'd0, errCode[0]}, 0);
        chk("g_clkCnt", clkCnt[0], 15);
        chk("g_check_err", {30'd0, errCode[1]}, 2);
        run(2, 1, 16'h0003);

        @(posedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/halt_monitor.md
HALT_MONITOR -- requirements
Module: halt_monitor

Interface
REQ-001 Parameter DATA_W, default 16, width of monitored result word.
REQ-002 Parameter CNT_W, default 32, width of cycle counters.
REQ-003 Parameter TIMEOUT, default 3000, max enabled cycles allowed before halt.
REQ-004 Parameter SETTLE_CYCLES, default 5, cycles after halt before completion; legal range 1..255.
REQ-005 Parameter CHECK_EN, default 0, 1 enables timeout/stability error checks.
REQ-006 clk  input  1  sole clock, all state updates on rising edge.
REQ-007 rstn  input  1  reset; asynchronous, active-low.
REQ-008 en  input  1  count/monitor enable; low freezes all state.
REQ-009 halt  input  1  DUT halt indication.
REQ-010 firstWord  input  DATA_W  DUT result word.
REQ-011 done  output  1  terminal state reached (success or error).
REQ-012 pass  output  1  done with no error.
REQ-013 errCode  output  2  0 none, 1 timeout, 2 halt deasserted, 3 word changed.
REQ-014 wordAtHalt  output  DATA_W  firstWord captured at first halt.
REQ-015 clkAtHalt  output  CNT_W  clkCnt value at first halt.
REQ-016 clkCnt  output  CNT_W  enabled-cycle count.

Function
REQ-017 FSM states RUN, SETTLE, DONE, ERROR; outputs registered, no combinational input-to-output path.
REQ-018 Only edges with en=1 in RUN or SETTLE are "active edges"; clkCnt increments by 1 on each, saturating at 2^CNT_W-1.
REQ-019 In RUN, active edge with halt=1: wordAtHalt<=firstWord, clkAtHalt<=new clkCnt, settle counter<=0, go SETTLE.
REQ-020 In RUN, CHECK_EN=1, active edge with halt=0 and new clkCnt > TIMEOUT: errCode<=1, go ERROR; halt=1 on same edge wins (REQ-019).
REQ-021 In SETTLE, CHECK_EN=1, active edge with halt=0: errCode<=2, go ERROR.
REQ-022 In SETTLE, CHECK_EN=1, active edge with firstWord!=wordAtHalt and halt=1: errCode<=3, go ERROR; code 2 has priority over 3.
REQ-023 In SETTLE, active edge without error: settle counter increments; when new clkCnt - clkAtHalt == SETTLE_CYCLES go DONE; error checks on same edge take priority.
REQ-024 With CHECK_EN=0, no errors raised; halt deassertion in SETTLE ignored; completion still after SETTLE_CYCLES.
REQ-025 DONE and ERROR sticky until reset; clkCnt, wordAtHalt, clkAtHalt frozen there.
REQ-026 done=1 in DONE or ERROR; pass=1 only in DONE; errCode=0 in DONE.
REQ-027 Only first halt captured; later halt edges never overwrite capture registers.

Reset
REQ-028 rstn low asynchronously forces RUN, clkCnt=0, clkAtHalt=0, wordAtHalt=0, errCode=0, done=0, pass=0, settle counter=0.
REQ-029 Reset asserted mid-SETTLE or in DONE/ERROR discards capture; monitoring restarts from first active edge after rstn release.

Structure
REQ-030 Package halt_monitor_pkg holds state enum and errCode enum constants (ERR_NONE, ERR_TIMEOUT, ERR_HALT_DROP, ERR_WORD_CHG).
REQ-031 One sub-module sat_counter (parametrised width, enable, sync clear, saturation) used for clkCnt and settle counter.

Verification (DATA_W=16, TIMEOUT=3000, SETTLE_CYCLES=5)
REQ-032 CHECK_EN=1, halt rises on active edge 100 with firstWord=0x1234, held stable -> clkAtHalt=100, wordAtHalt=0x1234, done=pass=1 after edge 105, clkCnt frozen at 105.
REQ-033 CHECK_EN=1, halt never rises -> errCode=1, done=1, pass=0 at edge 3001; halt at edge 3001 instead -> SETTLE, no error.
REQ-034 CHECK_EN=1, halt at edge 50, drops at edge 52 while firstWord also changes -> errCode=2 at edge 52.
REQ-035 CHECK_EN=1, halt at edge 50, firstWord changes 0x0007->0x0008 at edge 55 -> errCode=3, not DONE.
REQ-036 en low 10 cycles in SETTLE -> clkCnt and completion delayed exactly 10 cycles; rstn pulsed mid-SETTLE -> all outputs zero immediately, new halt at edge 20 captured normally.
REQ-037 CHECK_EN=0, halt at edge 10 then drops at 12 -> no error, done=pass=1 after edge 15.
